// File: rtl/pong_audio_pkg.sv
// Shared state and tone-code definitions for the Pong audio path.
package pong_audio_pkg;

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [1:0] TONE_OFF    = 2'd0;
  localparam logic [1:0] TONE_PADDLE = 2'd1;
  localparam logic [1:0] TONE_WALL   = 2'd2;
  localparam logic [1:0] TONE_SCORE  = 2'd3;

endpackage

// File: rtl/pong_tone_divider.sv
// Square-wave divider: toggles audio_out every half_period cycles while enabled.
module pong_tone_divider #(
  parameter int CNT_W = 17,
  parameter int PER_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             enable,
  input  logic [PER_W-1:0] half_period,
  output logic             audio_out
);

  logic [CNT_W-1:0] half_cnt;

  // restart wins over everything so a retrigger always begins with a fresh high phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt  <= '0;
      audio_out <= 1'b0;
    end else if (restart) begin
      half_cnt  <= '0;
      audio_out <= 1'b1;
    end else if (!enable) begin
      half_cnt  <= '0;
      audio_out <= 1'b0;
    end else if (half_cnt == CNT_W'(half_period - PER_W'(1))) begin
      half_cnt  <= '0;
      audio_out <= ~audio_out;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_tone_generator.sv
// One-shot square-wave burst generator driven by the 2-bit tone PIO code.
module pong_tone_generator
  import pong_audio_pkg::*;
#(
  parameter int HALF_PERIOD_1 = 56818,
  parameter int HALF_PERIOD_2 = 28409,
  parameter int HALF_PERIOD_3 = 113636,
  parameter int BURST_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tone_sel,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] tone_active
);

  localparam int MAX_12  = (HALF_PERIOD_1 > HALF_PERIOD_2) ? HALF_PERIOD_1 : HALF_PERIOD_2;
  localparam int MAX_HP  = (MAX_12 > HALF_PERIOD_3) ? MAX_12 : HALF_PERIOD_3;
  localparam int CNT_W   = (MAX_HP > 1) ? $clog2(MAX_HP) : 1;
  localparam int PER_W   = $clog2(MAX_HP + 1);
  localparam int BURST_W = $clog2(BURST_CYCLES + 1);

  state_t             state;
  logic [1:0]         tone_prev;
  logic [BURST_W-1:0] burst_cnt;
  logic [PER_W-1:0]   half_period;
  logic               trigger;
  logic               burst_last;
  logic               divider_en;

  assign trigger    = (tone_sel != tone_prev) && (tone_sel != TONE_OFF);
  assign burst_last = (burst_cnt == BURST_W'(BURST_CYCLES - 1));
  assign divider_en = (state == PLAY) && !burst_last;

  // Code 0 never plays; it falls back to the paddle period so the mux has no gap.
  always_comb begin
    half_period = PER_W'(HALF_PERIOD_1);
    case (tone_active)
      TONE_PADDLE: half_period = PER_W'(HALF_PERIOD_1);
      TONE_WALL:   half_period = PER_W'(HALF_PERIOD_2);
      TONE_SCORE:  half_period = PER_W'(HALF_PERIOD_3);
      default:     half_period = PER_W'(HALF_PERIOD_1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tone_prev   <= TONE_OFF;
      burst_cnt   <= '0;
      busy        <= 1'b0;
      tone_active <= TONE_OFF;
    end else begin
      tone_prev <= tone_sel;
      case (state)
        IDLE: begin
          if (trigger) begin
            state       <= PLAY;
            burst_cnt   <= '0;
            busy        <= 1'b1;
            tone_active <= tone_sel;
          end
        end
        PLAY: begin
          // A retrigger on the final cycle restarts rather than ending the burst.
          if (trigger) begin
            burst_cnt   <= '0;
            busy        <= 1'b1;
            tone_active <= tone_sel;
          end else if (burst_last) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            busy        <= 1'b0;
            tone_active <= TONE_OFF;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          burst_cnt   <= '0;
          busy        <= 1'b0;
          tone_active <= TONE_OFF;
        end
      endcase
    end
  end

  pong_tone_divider #(
    .CNT_W(CNT_W),
    .PER_W(PER_W)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .restart    (trigger),
    .enable     (divider_en),
    .half_period(half_period),
    .audio_out  (audio_out)
  );

endmodule

// File: tb/tb_pong_tone_generator.sv
// Self-checking bench: directed Pong sound scenarios followed by random code changes.
module tb_pong_tone_generator;

  localparam int HP1   = 4;
  localparam int HP2   = 2;
  localparam int HP3   = 8;
  localparam int BURST = 40;

  logic       clk;
  logic       reset;
  logic [1:0] tone_sel;
  logic       audio_out;
  logic       busy;
  logic [1:0] tone_active;

  int checks = 0;
  int errors = 0;

  // Reference model: a burst is just "which code, how many cycles since it started"
  bit       mPlaying;
  int       mElapsed;
  int       mCode;
  int       mPrevSel;
  bit       expAudio;
  bit       expBusy;
  bit [1:0] expTone;

  pong_tone_generator #(
    .HALF_PERIOD_1(HP1),
    .HALF_PERIOD_2(HP2),
    .HALF_PERIOD_3(HP3),
    .BURST_CYCLES (BURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tone_sel   (tone_sel),
    .audio_out  (audio_out),
    .busy       (busy),
    .tone_active(tone_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int halfPeriodOf(input int code);
    case (code)
      1:       return HP1;
      2:       return HP2;
      3:       return HP3;
      default: return HP1;
    endcase
  endfunction

  task automatic modelReset();
    mPlaying = 1'b0;
    mElapsed = 0;
    mCode    = 0;
    mPrevSel = 0;
  endtask

  // Applies one clock edge to the model using the input values present at that edge.
  task automatic modelEdge(input int sel, input bit rst);
    if (rst) begin
      modelReset();
    end else begin
      if (sel != 0 && sel != mPrevSel) begin
        mPlaying = 1'b1;
        mCode    = sel;
        mElapsed = 0;
      end else if (mPlaying) begin
        if (mElapsed == BURST - 1) begin
          mPlaying = 1'b0;
          mCode    = 0;
          mElapsed = 0;
        end else begin
          mElapsed++;
        end
      end
      mPrevSel = sel;
    end
  endtask

  task automatic checkOutput(input string tag);
    expBusy  = mPlaying;
    expTone  = mPlaying ? 2'(mCode) : 2'd0;
    expAudio = mPlaying && (((mElapsed / halfPeriodOf(mCode)) % 2) == 0);
    checks += 3;
    assert (busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy: got %0b expected %0b at %0t", tag, busy, expBusy, $time);
    end
    assert (tone_active === expTone) else begin
      errors++;
      $error("[TB] FAIL %s tone_active: got %0d expected %0d at %0t", tag, tone_active, expTone, $time);
    end
    assert (audio_out === expAudio) else begin
      errors++;
      $error("[TB] FAIL %s audio_out: got %0b expected %0b at %0t", tag, audio_out, expAudio, $time);
    end
  endtask

  // Drive a code, then run n edges, checking every cycle 1 time unit after the edge.
  task automatic applyStimulus(input logic [1:0] code, input int n, input string tag);
    int sel;
    bit rst;
    tone_sel = code;
    for (int i = 0; i < n; i++) begin
      sel = int'(tone_sel);
      rst = reset;
      @(posedge clk);
      modelEdge(sel, rst);
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic pulseReset(input string tag);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput({tag, "_async"});
    applyStimulus(tone_sel, 3, {tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] rcode;
    int         rlen;
    reset    = 1'b1;
    tone_sel = 2'd0;
    modelReset();
    #12;
    checkOutput("reset_state");
    applyStimulus(2'd0, 2, "reset_hold");
    reset = 1'b0;
    applyStimulus(2'd0, 3, "idle");

    $display("[TB] paddle burst with code held");
    applyStimulus(2'd1, 55, "paddle_hold");

    $display("[TB] replay via 0 then 1");
    applyStimulus(2'd0, 3, "replay_zero");
    applyStimulus(2'd1, 45, "replay_one");

    $display("[TB] retrigger to wall at burst_cnt 10");
    applyStimulus(2'd0, 2, "wall_pre");
    applyStimulus(2'd1, 11, "wall_first");
    applyStimulus(2'd2, 55, "wall_retrig");

    $display("[TB] retrigger on final burst cycle");
    applyStimulus(2'd0, 2, "last_pre");
    applyStimulus(2'd3, 40, "last_score");
    applyStimulus(2'd1, 50, "last_retrig");

    $display("[TB] code released mid-burst");
    applyStimulus(2'd0, 2, "release_pre");
    applyStimulus(2'd3, 6, "release_score");
    applyStimulus(2'd0, 45, "release_zero");

    $display("[TB] reset mid-burst with code held");
    applyStimulus(2'd3, 21, "rst_burst");
    pulseReset("rst_mid");
    applyStimulus(2'd3, 45, "rst_after");

    $display("[TB] random code sequence");
    for (int s = 0; s < 40; s++) begin
      rcode = 2'($urandom_range(0, 3));
      rlen  = int'($urandom_range(1, 60));
      applyStimulus(rcode, rlen, "random");
      if ($urandom_range(0, 15) == 0) pulseReset("random_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
